wrapper_host_seq: RTL

//  Host-side initiator for the 2-bit opcode / 19-bit data inference port (0=idle, 1=write, 2=info).

---
 rtl/wrapper_host_seq_if.sv | 24 ++
 rtl/wrapper_host_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wrapper_host_seq_if.sv
// Host-side bundle for the inference port (opcode/data/status/result) and the sample stream.
// The master modport is the initiator view; the slave modport is the port/model view.
interface wrapper_host_seq_if #(
  parameter int unsigned DW = 19,
  parameter int unsigned RW = 7
);
  logic [1:0]    opcode;
  logic [DW-1:0] data;
  logic [1:0]    status;
  logic [RW-1:0] result;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (
    output opcode, data, s_ready,
    input  status, result, s_valid, s_data
  );

  modport slave (
    input  opcode, data, s_ready,
    output status, result, s_valid, s_data
  );
endinterface

// File: rtl/wrapper_host_seq.sv
// Host-side initiator: streams a sample set into the inference port with write commands,
// issues one info command, then tracks port status and captures the result.
module wrapper_host_seq #(
  parameter int unsigned DW      = 19,
  parameter int unsigned RW      = 7,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned BUSY_TO = 4,
  parameter int unsigned DONE_TO = 1023
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_i,
  input  logic [7:0]          nwords_i,
  input  logic [7:0]          read_len_i,
  input  logic [7:0]          count_len_i,
  wrapper_host_seq_if.master  port_io,
  output logic                busy_o,
  output logic                res_valid_o,
  output logic [RW-1:0]       res_o,
  output logic                err_o
);

  typedef enum logic [2:0] {StIdle, StLoad, StIssue, StWaitBusy, StWaitDone, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    nwords_q, nwords_d;
  logic [7:0]    read_len_q, read_len_d;
  logic [7:0]    count_len_q, count_len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [9:0]    tmr_q, tmr_d;
  logic [1:0]    opcode_q, opcode_d;
  logic [DW-1:0] data_q, data_d;
  logic          s_ready_q, s_ready_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [RW-1:0] res_q, res_d;
  logic          err_q, err_d;

  logic [8:0]    len_sum;
  logic          hs;
  logic [DW-1:0] info_word;

  // The port count timer is 8 bits, so the summed lengths must fit without wrapping.
  assign len_sum = {1'b0, read_len_i} + {1'b0, count_len_i};
  assign hs      = port_io.s_valid & s_ready_q;

  always_comb begin
    info_word        = '0;
    info_word[7:0]   = read_len_q;
    info_word[17:10] = count_len_q;
  end

  always_comb begin
    state_d     = state_q;
    nwords_d    = nwords_q;
    read_len_d  = read_len_q;
    count_len_d = count_len_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    opcode_d    = 2'd0;
    data_d      = '0;
    s_ready_d   = 1'b0;
    res_valid_d = 1'b0;
    res_d       = res_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if ((32'(nwords_i) > DEPTH) || (len_sum == 9'd0) || len_sum[8]) begin
            err_d = 1'b1;
          end else begin
            nwords_d    = nwords_i;
            read_len_d  = read_len_i;
            count_len_d = count_len_i;
            cnt_d       = 8'd0;
            if (nwords_i == 8'd0) begin
              state_d = StIssue;
            end else begin
              state_d   = StLoad;
              s_ready_d = 1'b1;
            end
          end
        end
      end
      StLoad: begin
        s_ready_d = 1'b1;
        if (hs) begin
          opcode_d = 2'd1;
          data_d   = port_io.s_data;
          cnt_d    = cnt_q + 8'd1;
          if (cnt_q == nwords_q - 8'd1) begin
            s_ready_d = 1'b0;
            state_d   = StIssue;
          end
        end
      end
      StIssue: begin
        tmr_d = 10'd0;
        // Hold the info command back while the port still reports busy.
        if (port_io.status != 2'd1) begin
          opcode_d = 2'd2;
          data_d   = info_word;
          state_d  = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (port_io.status == 2'd1) begin
          tmr_d   = 10'd0;
          state_d = StWaitDone;
        end else if (tmr_q == 10'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 10'd1;
        end
      end
      StWaitDone: begin
        if (port_io.status == 2'd2) begin
          res_d       = port_io.result;
          res_valid_d = 1'b1;
          state_d     = StDone;
        end else if (port_io.status == 2'd1) begin
          tmr_d = 10'd0;
        end else if (tmr_q == 10'(DONE_TO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 10'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      nwords_q    <= 8'd0;
      read_len_q  <= 8'd0;
      count_len_q <= 8'd0;
      cnt_q       <= 8'd0;
      tmr_q       <= 10'd0;
      opcode_q    <= 2'd0;
      data_q      <= '0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      nwords_q    <= nwords_d;
      read_len_q  <= read_len_d;
      count_len_q <= count_len_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      opcode_q    <= opcode_d;
      data_q      <= data_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      err_q       <= err_d;
    end
  end

  assign port_io.opcode  = opcode_q;
  assign port_io.data    = data_q;
  assign port_io.s_ready = s_ready_q;
  assign busy_o          = busy_q;
  assign res_valid_o     = res_valid_q;
  assign res_o           = res_q;
  assign err_o           = err_q;

endmodule
